debug_vjtag_scan_master: RTL and testbench

- Host-side driver for the Nios II debug slave's virtual-JTAG interface.
- Takes one command (IR value + DR word) and generates the full virtual-JTAG sequence on the vji_* signals that the debug slave's tck block consumes: tck, tdi, ir_in and the uir/cdr/sdr/udr/rti strobes.
- Captures tdo and ir_out and returns them as a response.
- Used as an embedded debug controller and as the simulation stimulus for the debug slave in place of sld_virtual_jtag_basic.

---
 rtl/debug_vjtag_scan_master.sv | 147 ++++++++++++++
 tb/tb_debug_vjtag_scan_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_vjtag_scan_master.sv
// Host-side virtual-JTAG scan master: plays one IR/DR command onto the vji_* bus
// of the debug slave and returns the captured tdo bits and the slave's ir_out.
module debug_vjtag_scan_master #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned DIV_W = $clog2(TCK_DIV) + 1;
  localparam int unsigned BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] shift_q;

  // Every scan state spans whole tck periods: div_cnt counts clk cycles within the
  // current period, tck rises mid-period and state changes happen at period end.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            state     <= S_UIR;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            vji_ir_in <= cmd_ir;
            shift_q   <= cmd_data;
            div_cnt   <= '0;
            vji_tck   <= 1'b0;
            vji_uir   <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            vji_tck <= 1'b0;
            case (state)
              S_UIR: begin
                state   <= S_CDR;
                vji_uir <= 1'b0;
                vji_cdr <= 1'b1;
              end
              S_CDR: begin
                state   <= S_SDR;
                vji_cdr <= 1'b0;
                vji_sdr <= 1'b1;
                bit_cnt <= '0;
                vji_tdi <= shift_q[0];
                shift_q <= shift_q >> 1;
              end
              S_SDR: begin
                if (bit_cnt == BIT_LAST) begin
                  state   <= S_UDR;
                  vji_sdr <= 1'b0;
                  vji_udr <= 1'b1;
                  vji_tdi <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  vji_tdi <= shift_q[0];
                  shift_q <= shift_q >> 1;
                end
              end
              S_UDR: begin
                state   <= S_RTI;
                vji_udr <= 1'b0;
                vji_rti <= 1'b1;
              end
              S_RTI: begin
                state     <= S_RESP;
                vji_rti   <= 1'b0;
                rsp_valid <= 1'b1;
              end
              default: state <= S_IDLE;
            endcase
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            // tck rising edge: the slave's outputs are sampled here
            if (div_cnt == DIV_RISE) begin
              vji_tck <= 1'b1;
              if (state == S_UIR) rsp_ir_out <= vji_ir_out;
              if (state == S_SDR) rsp_data <= DR_WIDTH'({vji_tdo, rsp_data} >> 1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_vjtag_scan_master.sv
// Randomized bench for debug_vjtag_scan_master: a cycle-position model derived from
// the scan-sequence rules predicts every output; a slave model supplies tdo/ir_out.
module tb_debug_vjtag_scan_master;

  localparam int unsigned DR  = 38;
  localparam int unsigned IRW = 2;
  localparam int unsigned TD  = 2;
  localparam int          LAT = (DR + 4) * 2 * TD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [IRW-1:0] cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [DR-1:0]  cmd_data, rsp_data;
  logic           vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic           c1_valid, c1_ready, r1_valid, r1_ready, busy1;
  logic [IRW-1:0] c1_ir, r1_ir_out, ir_in1;
  logic [DR-1:0]  c1_data, r1_data;
  logic           tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;

  // Slave model: either loops tdi back or shifts a pattern out LSB first
  logic          loop_mode;
  logic [DR-1:0] pat;
  logic [5:0]    idx;
  always @(posedge vji_tck) begin
    if (vji_cdr) idx <= 6'd0;
    else if (vji_sdr) idx <= idx + 6'd1;
  end
  assign vji_tdo = loop_mode ? vji_tdi : ((idx < 6'(DR)) ? pat[idx] : 1'b0);

  debug_vjtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .busy(busy), .vji_tck(vji_tck),
    .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti));

  debug_vjtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_ir(c1_ir), .cmd_data(c1_data), .rsp_valid(r1_valid), .rsp_ready(r1_ready),
    .rsp_data(r1_data), .rsp_ir_out(r1_ir_out), .busy(busy1), .vji_tck(tck1),
    .vji_tdi(tdi1), .vji_tdo(tdi1), .vji_ir_in(ir_in1), .vji_ir_out(2'b11),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {tck, uir, cdr, sdr, udr, rti, tdi, rsp_valid, busy, cmd_ready} k cycles
  // after the accept edge, from period arithmetic alone.
  function automatic logic [9:0] expect_vec(input int k, input int t, input logic [DR-1:0] d);
    int per, ph;
    logic tck, tdi;
    logic [4:0] st;
    if (k >= (DR + 4) * 2 * t) return 10'b0_00000_0_1_1_0;
    per = k / (2 * t);
    ph  = k % (2 * t);
    tck = (ph >= t);
    tdi = 1'b0;
    if (per == 0) st = 5'b10000;
    else if (per == 1) st = 5'b01000;
    else if (per <= int'(DR) + 1) begin
      st  = 5'b00100;
      tdi = d[per-2];
    end else if (per == int'(DR) + 2) st = 5'b00010;
    else st = 5'b00001;
    return {tck, st, tdi, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi,
            rsp_valid, busy, cmd_ready};
  endfunction

  // One command end to end; called and returning on a negedge.
  task automatic run_scan(input logic [IRW-1:0] ir, input logic [DR-1:0] d, input bit loop,
                          input logic [DR-1:0] p, input logic [IRW-1:0] iro,
                          input int abort_k, input int hold);
    logic [DR-1:0] exp_data;
    int w;
    loop_mode  = loop;
    pat        = p;
    vji_ir_out = iro;
    exp_data   = loop ? d : p;
    cmd_ir     = ir;
    cmd_data   = d;
    cmd_valid  = 1'b1;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 38'({$urandom(), $urandom()});
    cmd_ir    = 2'($urandom());
    @(negedge clk);
    for (int k = 0; k <= LAT; k++) begin
      if (k == abort_k) begin
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_state", 64'({vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
              vji_tdi, rsp_valid, busy, rsp_data}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
        return;
      end
      check("cycle", 64'(obs_vec()), 64'(expect_vec(k, TD, d)));
      if (k == 0) check("ir_in", 64'(vji_ir_in), 64'(ir));
      if (k < LAT) @(negedge clk);
    end
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_ir_out", 64'(rsp_ir_out), 64'(iro));
    check("ir_in_held", 64'(vji_ir_in), 64'(ir));
    // Response held back while a new command is offered
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold", 64'({rsp_valid, cmd_ready, busy, vji_tck, vji_uir, rsp_data, rsp_ir_out}),
            64'({3'b101, 2'b00, exp_data, iro}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("release", 64'({busy, rsp_valid, cmd_ready, vji_tck}), 64'(4'b0010));
  endtask

  task automatic run_fast();
    int k;
    c1_ir    = 2'b10;
    c1_data  = '1;
    c1_valid = 1'b1;
    k = 0;
    while (!c1_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    c1_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!r1_valid && k < 200) begin
      check("tck1", 64'(tck1), 64'(k % 2));
      @(negedge clk);
      k++;
    end
    check("lat1", 64'(k), 64'(84));
    check("data1", 64'(r1_data), 64'({DR{1'b1}}));
    check("ir1", 64'({ir_in1, r1_ir_out}), 64'(4'b1011));
    r1_ready = 1'b1;
    @(posedge clk);
    #1;
    r1_ready = 1'b0;
    @(negedge clk);
    check("release1", 64'({busy1, r1_valid, c1_ready}), 64'(3'b001));
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ir     = '0;
    cmd_data   = '0;
    rsp_ready  = 1'b0;
    vji_ir_out = '0;
    loop_mode  = 1'b1;
    pat        = '0;
    c1_valid   = 1'b0;
    c1_ir      = '0;
    c1_data    = '0;
    r1_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", 64'({vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi,
          vji_ir_in, rsp_valid, busy, rsp_ir_out}), 64'(0));
    check("reset_data", 64'(rsp_data), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'({cmd_ready, busy}), 64'(2'b10));

    run_scan(2'b01, 38'h2A_5A5A_A5A5, 1'b1, '0, 2'b00, -1, 20);
    run_scan(2'b11, 38'h15_1234_5678, 1'b0, 38'h3F_0000_0001, 2'b10, -1, 3);
    for (int i = 0; i < 5; i++)
      run_scan(2'($urandom()), 38'({$urandom(), $urandom()}), 1'($urandom()),
               38'({$urandom(), $urandom()}), 2'($urandom()), -1, int'($urandom_range(0, 6)));
    // Abort during SDR bit 17 (scan period 19), then a normal scan
    run_scan(2'b10, 38'({$urandom(), $urandom()}), 1'b1, '0, 2'b01, 19 * 2 * TD + 1, 0);
    run_scan(2'b10, 38'h00_FFFF_0000, 1'b1, '0, 2'b01, -1, 2);
    run_fast();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
